// File: rtl/spi_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl_pkg
// Purpose  : Shared constants for the SPI master controller and the slave-side
//            RAM decode: FSM state encoding, frame opcodes, and the
//            bit-counter terminal values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_master_ctrl_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_WAIT_RD = 3'd5;
  localparam logic [2:0] ST_RECV    = 3'd6;
  localparam logic [2:0] ST_GAP     = 3'd7;

  // Frame opcodes carried in frame[9:8]
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Frame geometry
  localparam int         FRAME_W    = 10;
  localparam int         DATA_W     = 8;
  localparam logic [3:0] SHIFT_LAST = 4'd9;  // 10 frame bits
  localparam logic [3:0] RECV_LAST  = 4'd7;  // 8 MISO samples

  // Slave select is driven low in every state between IDLE and GAP.
  function automatic logic ss_active(input logic [2:0] st);
    return !((st == ST_IDLE) || (st == ST_GAP));
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift_reg
// Purpose  : Parallel-load, MSB-first shift register. Shifting moves every bit
//            one place towards the MSB and inserts shift_in at the LSB, so
//            q[WIDTH-1] is the next bit to go out.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            load, load_data  - parallel load (takes priority over shift)
//            shift_en         - shift one place this cycle
//            shift_in         - bit entering at the LSB
//            q                - register contents
// Revision : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], shift_in};
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : SPI master that serialises 10-bit request frames (2-bit opcode +
//            8-bit payload) MSB first, holds SS_n low for a trailing period,
//            and for read-data frames waits RD_WAIT cycles and then samples
//            one byte from MISO, reporting it with a one-cycle rsp_valid.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            req_valid, req_frame  - request handshake input
//            req_ready             - high only while idle
//            SS_n, MOSI, MISO      - SPI pins
//            rsp_valid, rsp_data   - read-back byte, pulsed once per read
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int WR_HOLD = 2,
  parameter int RD_WAIT = 4,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FRAME_W-1:0] req_frame,
  output logic               req_ready,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data
);

  // One delay counter serves HOLD, WAIT_RD and GAP; size it for the longest.
  localparam int DLY_MAX = (WR_HOLD > RD_WAIT) ? ((WR_HOLD > GAP) ? WR_HOLD : GAP)
                                               : ((RD_WAIT > GAP) ? RD_WAIT : GAP);
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(WR_HOLD - 1);
  localparam logic [DLY_W-1:0] WAIT_LAST = DLY_W'(RD_WAIT - 1);
  localparam logic [DLY_W-1:0] GAP_LAST  = DLY_W'(GAP - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [3:0]         r_bit_cnt;
  logic [DLY_W-1:0]   r_dly_cnt;
  logic [1:0]         r_op;
  logic               w_accept;
  logic [FRAME_W-1:0] w_tx_q;
  logic [DATA_W-1:0]  w_rx_q;
  logic               w_last_sample;
  logic               unused_bits;

  assign req_ready     = rst_n && (r_state == ST_IDLE);
  assign w_accept      = req_valid && req_ready;
  assign w_last_sample = (r_state == ST_RECV) && (r_bit_cnt == RECV_LAST);

  // Only the top two transmit bits and the low seven receive bits are read
  // directly; the rest exist purely as shift storage.
  assign unused_bits = ^{w_tx_q[FRAME_W-3:0], w_rx_q[DATA_W-1]};

  // The frame is captured at acceptance so later req_frame changes are ignored.
  spi_shift_reg #(.WIDTH(FRAME_W)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_accept),
    .load_data (req_frame),
    .shift_en  (r_state == ST_SHIFT),
    .shift_in  (1'b0),
    .q         (w_tx_q)
  );

  spi_shift_reg #(.WIDTH(DATA_W)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_accept),
    .load_data ('0),
    .shift_en  (r_state == ST_RECV),
    .shift_in  (MISO),
    .q         (w_rx_q)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_START;
      ST_START:   w_next = ST_CMD;
      ST_CMD:     w_next = ST_SHIFT;
      ST_SHIFT:   if (r_bit_cnt == SHIFT_LAST)
                    w_next = (r_op == OP_RD_DATA) ? ST_WAIT_RD : ST_HOLD;
      ST_HOLD:    if (r_dly_cnt == HOLD_LAST) w_next = ST_GAP;
      ST_WAIT_RD: if (r_dly_cnt == WAIT_LAST) w_next = ST_RECV;
      ST_RECV:    if (r_bit_cnt == RECV_LAST) w_next = ST_GAP;
      ST_GAP:     if (r_dly_cnt == GAP_LAST)  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_dly_cnt <= '0;
      r_op      <= OP_WR_ADDR;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      r_state <= w_next;

      if (w_accept) r_op <= req_frame[FRAME_W-1 -: 2];

      // Counters restart on every state change and run only where they matter.
      if (w_next != r_state) begin
        r_bit_cnt <= '0;
        r_dly_cnt <= '0;
      end else begin
        if ((r_state == ST_SHIFT) || (r_state == ST_RECV))
          r_bit_cnt <= r_bit_cnt + 4'd1;
        if ((r_state == ST_HOLD) || (r_state == ST_WAIT_RD) || (r_state == ST_GAP))
          r_dly_cnt <= r_dly_cnt + DLY_W'(1);
      end

      // Pins are registered from the next state so they line up with r_state.
      SS_n <= !ss_active(w_next);

      // The transmit register shifts on the same edge that loads MOSI, so
      // inside SHIFT the upcoming bit already sits one place below the MSB.
      case (w_next)
        ST_CMD:   MOSI <= w_tx_q[FRAME_W-1];
        ST_SHIFT: MOSI <= (r_state == ST_SHIFT) ? w_tx_q[FRAME_W-2] : w_tx_q[FRAME_W-1];
        default:  MOSI <= 1'b0;
      endcase

      rsp_valid <= w_last_sample;
      if (w_last_sample) rsp_data <= {w_rx_q[DATA_W-2:0], MISO};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Purpose  : Testbench for spi_master_ctrl. A behavioural SPI slave with a
//            256-byte RAM decodes each frame from MOSI and answers read-data
//            frames on MISO; a queue of expected frames and responses is
//            filled on acceptance and checked when each frame ends.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

  localparam int WR_HOLD = 2;
  localparam int RD_WAIT = 4;
  localparam int GAP     = 1;
  localparam int WR_LEN  = 12 + WR_HOLD;
  localparam int RD_LEN  = 12 + RD_WAIT + 8;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic [9:0] req_frame = '0;
  logic       MISO      = 1'b0;
  logic       req_ready;
  logic       SS_n;
  logic       MOSI;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .WR_HOLD (WR_HOLD),
    .RD_WAIT (RD_WAIT),
    .GAP     (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_frame (req_frame),
    .req_ready (req_ready),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  typedef struct {
    logic [9:0] frame;
    logic [7:0] rsp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t sb_q[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int i, input logic [9:0] f);
    if (i == 1) return f[9];
    if (i >= 2 && i <= 11) return f[11-i];
    return 1'b0;
  endfunction

  // ---------------- slave model + frame monitor ----------------
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [7:0]  s_addr    = 8'h00;
  logic [7:0]  tx_byte   = 8'h00;
  logic [7:0]  last_rsp  = 8'h00;
  logic [63:0] got_v     = '0;
  logic [63:0] ev;
  logic [9:0]  cf;
  int          p         = 0;
  int          hi_cnt    = 1000;
  bit          in_frame  = 0;
  bit          rd_frame  = 0;
  bit          fend;
  bit          is_rd;
  vec_t        e;

  always @(negedge clk) begin
    fend = 0;
    if (!rst_n) begin
      p = 0; in_frame = 0; hi_cnt = 1000; last_rsp = 8'h00; MISO = 1'b0;
      chk("rst_ss_n", SS_n, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
    end else if (SS_n == 1'b0) begin
      if (!in_frame) begin
        in_frame = 1; p = 0; got_v = '0; rd_frame = 0;
        chk("gap_len", hi_cnt >= GAP + 1, 1);
      end
      hi_cnt = 0;
      if (p < 64) got_v[p] = MOSI;
      if (p == 11) begin
        for (int k = 0; k < 10; k++) cf[9-k] = got_v[2+k];
        case (cf[9:8])
          2'b00: s_addr = cf[7:0];
          2'b01: mem[s_addr] = cf[7:0];
          2'b10: s_addr = cf[7:0];
          default: begin tx_byte = mem[s_addr]; rd_frame = 1; end
        endcase
      end
      if (rd_frame && p >= 12 + RD_WAIT && p < 12 + RD_WAIT + 8)
        MISO = tx_byte[7 - (p - 12 - RD_WAIT)];
      else
        MISO = 1'($urandom_range(0, 1));
      p++;
    end else begin
      if (in_frame) begin
        fend = 1; in_frame = 0;
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          is_rd = (e.frame[9:8] == 2'b11);
          ev = '0;
          for (int i = 0; i < p && i < 64; i++) ev[i] = exp_bit(i, e.frame);
          chk("frame_len", p, is_rd ? RD_LEN : WR_LEN);
          chk("mosi_seq", got_v, ev);
          if (is_rd) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, e.rsp);
            last_rsp = e.rsp;
          end else begin
            chk("no_rsp_on_write", rsp_valid, 0);
            chk("rsp_data_held", rsp_data, last_rsp);
          end
        end
      end
      chk("idle_mosi", MOSI, 0);
      hi_cnt++;
      MISO = 1'($urandom_range(0, 1));
    end
    if (rst_n && !fend && rsp_valid) chk("stray_rsp_valid", rsp_valid, 0);
    if (rst_n && req_ready) chk("ready_only_idle", (SS_n === 1'b1) && (hi_cnt >= GAP + 1), 1);
  end

  // ---------------- driver ----------------
  task automatic send(input logic [9:0] f, input logic [7:0] r, input bit hold);
    int   n = 0;
    vec_t v;
    @(negedge clk);
    req_valid = 1'b1;
    req_frame = f;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    v.frame = f;
    v.rsp   = r;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    req_frame = 10'($urandom);  // must not disturb the frame in flight
    req_valid = hold;
    chk("ready_drop", req_ready, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || SS_n !== 1'b1) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{10'b00_1010_0101, 8'h00};
    tbl[1]  = '{10'h03C, 8'h00};  // wr addr 3C
    tbl[2]  = '{10'h1A7, 8'h00};  // wr data A7
    tbl[3]  = '{10'h23C, 8'h00};  // rd addr 3C
    tbl[4]  = '{10'h300, 8'hA7};  // rd data
    tbl[5]  = '{10'h010, 8'h00};  // wr addr 10
    tbl[6]  = '{10'h15A, 8'h00};  // wr data 5A
    tbl[7]  = '{10'h210, 8'h00};  // rd addr 10
    tbl[8]  = '{10'h3FF, 8'h5A};  // rd data (payload ignored)
    tbl[9]  = '{10'h0FF, 8'h00};  // wr addr FF
    tbl[10] = '{10'h100, 8'h00};  // wr data 00
    tbl[11] = '{10'h000, 8'h00};  // wr addr 00
    tbl[12] = '{10'h1FF, 8'h00};  // wr data FF
    tbl[13] = '{10'h2FF, 8'h00};  // rd addr FF
    tbl[14] = '{10'h3AA, 8'h00};  // rd data -> 00
    tbl[15] = '{10'h200, 8'h00};  // rd addr 00

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ss_n", SS_n, 1);
    chk("reset_mosi", MOSI, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_reset", req_ready, 1);

    // Table of single frames
    for (int i = 0; i < 16; i++) send(tbl[i].frame, tbl[i].rsp, 1'b0);
    send(10'h355, 8'hFF, 1'b0);  // rd data from address 00
    send(10'h300, 8'hFF, 1'b0);  // repeated read, fresh pulse
    drain();

    // req_valid held high across consecutive frames
    send(10'h077, 8'h00, 1'b1);
    send(10'h1C3, 8'h00, 1'b1);
    send(10'h277, 8'h00, 1'b1);
    send(10'h300, 8'hC3, 1'b0);
    drain();

    // Reset during SHIFT cycle 5 of a read-data frame
    send(10'h355, 8'hC3, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_ss_low", SS_n, 0);
    #1 rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_mosi", MOSI, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_rsp_data", rsp_data, 8'h00);
    chk("abort_ready_low", req_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First frame after reset (slave address still 77)
    send(10'h300, 8'hC3, 1'b0);
    send(10'h0A5, 8'h00, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter WR_HOLD, default 2: cycles SS_n stays low after last frame bit on non-read-data frames.
REQ-002 Parameter RD_WAIT, default 4: cycles between last frame bit and first MISO sample on read-data frames.
REQ-003 Parameter GAP, default 1: minimum cycles SS_n is high between frames.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request frame present.
REQ-007 req_frame  input  10  frame; [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 SS_n  output  1  slave select, active low.
REQ-010 MOSI  output  1  serial data to slave.
REQ-011 MISO  input  1  serial data from slave.
REQ-012 rsp_valid  output  1  one-cycle pulse, rsp_data valid.
REQ-013 rsp_data  output  8  byte read back from slave.

Function
REQ-014 FSM states SHALL be IDLE, START, CMD, SHIFT, HOLD, WAIT_RD, RECV, GAP.
REQ-015 req_ready SHALL be 1 only in IDLE; transfer occurs when req_valid&&req_ready, frame latched into 10-bit shift register.
REQ-016 IDLE: SS_n=1, MOSI=0; on accept -> START.
REQ-017 START: one cycle, SS_n=0, MOSI=0 -> CMD.
REQ-018 CMD: one cycle, MOSI=frame[9] -> SHIFT.
REQ-019 SHIFT: exactly 10 cycles, MOSI=frame[9] down to frame[0], MSB first, 4-bit counter.
REQ-020 After SHIFT: opcode 11 -> WAIT_RD; otherwise -> HOLD.
REQ-021 HOLD: WR_HOLD cycles SS_n=0, MOSI=0 -> GAP.
REQ-022 WAIT_RD: RD_WAIT cycles SS_n=0, MOSI=0 -> RECV.
REQ-023 RECV: 8 cycles; each rising edge shifts MISO into rsp_data LSB, first sample = bit 7.
REQ-024 rsp_valid SHALL pulse for exactly one cycle, in the cycle after the 8th MISO sample; rsp_data held until next read-data response.
REQ-025 GAP: SS_n=1 for GAP cycles -> IDLE; no request accepted during GAP.
REQ-026 SS_n SHALL never toggle within a frame; MOSI SHALL be 0 whenever SS_n=1.
REQ-027 req_frame changes after acceptance SHALL not affect the frame in flight.
REQ-028 Frame length: non-read = 12+WR_HOLD cycles SS_n low; read-data = 12+RD_WAIT+8 cycles SS_n low.
REQ-029 Back-to-back requests: next accept no earlier than GAP+1 cycles after SS_n rises.
REQ-030 All outputs SHALL be registered (no combinational path from MISO or req_* to outputs except req_ready decode of state).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, SS_n=1, MOSI=0, req_ready=0 while low, rsp_valid=0, rsp_data=8'h00, counters 0.
REQ-032 Reset mid-frame SHALL abort it with no rsp_valid; first frame after release starts from START.

Structure
REQ-033 Shared package SHALL hold state encoding constants and the four opcode constants (also used by the RAM decode).
REQ-034 One sub-module natural: spi_shift_reg (parameterised width, load/shift-out/shift-in); counters and FSM in top.

Verification
REQ-035 Write-addr frame 10'b00_1010_0101 -> SS_n low 14 cycles, MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1,0,0, no rsp_valid.
REQ-036 Full loop with SPI_slave_interface: write addr 8'h3C, write data 8'hA7, read addr 8'h3C, read data -> rsp_data=8'hA7 with single rsp_valid.
REQ-037 Responder model drives MISO 8'h5A at RD_WAIT offset -> rsp_data=8'h5A, rsp_valid one cycle after 8th sample.
REQ-038 req_valid held high for 3 frames -> req_ready only in IDLE, SS_n high >= GAP cycles between frames, frames emitted in order.
REQ-039 rst_n asserted in SHIFT cycle 5 of read-data frame -> SS_n=1, MOSI=0 same cycle, no rsp_valid; next frame correct.
